imul_divider: RTL and testbench

Sequential unsigned restoring divider, the inverse datapath of the team's 16x16 array multiplier: divides a 2·NB-bit dividend by an NB-bit divisor, one quotient bit per clock. Sits beside the multiplier in the arithmetic unit. It lets a multiplier product be divided back by either operand under a start/done handshake. Divide-by-zero and quotient overflow are flagged, not computed.

---
 rtl/imul_divider_pkg.sv | 20 ++
 rtl/imul_divider_div_step.sv | 55 +++++
 rtl/imul_divider.sv | 132 +++++++++++++
 tb/tb_imul_divider.sv | 211 +++++++++++++++++++++
 4 files changed

// File: rtl/imul_divider_pkg.sv
// ============================================================================
//  imul_divider_pkg
//  Shared state encoding and default width for the restoring divider.
//  Revision: 1.0
// ============================================================================
`default_nettype none

package imul_divider_pkg;

    localparam int NB_DEFAULT = 16;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } div_state_t;

endpackage

`default_nettype wire

// File: rtl/imul_divider_div_step.sv
// ============================================================================
//  imul_divider_div_step / imul_divider_full_adder
//  One restoring-division iteration: shift in a dividend bit, trial-subtract.
//  Revision: 1.0
// ============================================================================
`default_nettype none

module imul_divider_full_adder (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic s,
    output logic cout
);
    assign s    = a ^ b ^ cin;
    assign cout = (a & b) | ((a ^ b) & cin);
endmodule

module imul_divider_div_step #(
    parameter int NB = 16
) (
    input  logic [NB-1:0] p_in,
    input  logic          bit_in,
    input  logic [NB-1:0] divisor,
    output logic [NB-1:0] p_out,
    output logic          q_bit
);
    logic [NB:0]   w_shift;
    logic [NB:0]   w_subtrahend;
    logic [NB:0]   w_diff;
    logic [NB+1:0] w_carry;
    logic          w_nonneg;

    assign w_shift      = {p_in, bit_in};
    assign w_subtrahend = ~{1'b0, divisor};
    assign w_carry[0]   = 1'b1;

    // Two's-complement subtract: add the inverted divisor with carry-in 1
    for (genvar i = 0; i <= NB; i++) begin : g_ripple
        imul_divider_full_adder u_fa (
            .a   (w_shift[i]),
            .b   (w_subtrahend[i]),
            .cin (w_carry[i]),
            .s   (w_diff[i]),
            .cout(w_carry[i+1])
        );
    end

    // Carry-out and a clear sign bit agree while P < divisor holds
    assign w_nonneg = w_carry[NB+1] & ~w_diff[NB];
    assign q_bit    = w_nonneg;
    assign p_out    = w_nonneg ? w_diff[NB-1:0] : w_shift[NB-1:0];
endmodule

`default_nettype wire

// File: rtl/imul_divider.sv
// ============================================================================
//  imul_divider
//  Sequential unsigned 2NB/NB restoring divider with start/done handshake.
//  Revision: 1.0
// ============================================================================
`default_nettype none

module imul_divider
    import imul_divider_pkg::*;
#(
    parameter int NB = NB_DEFAULT
) (
    input  logic            Clock,
    input  logic            Reset_n,
    input  logic            iStart,
    input  logic [2*NB-1:0] iDividend,
    input  logic [NB-1:0]   iDivisor,
    output logic            oBusy,
    output logic            oDone,
    output logic [NB-1:0]   oQuotient,
    output logic [NB-1:0]   oRemainder,
    output logic            oDivByZero,
    output logic            oOverflow
);
    localparam int CW = $clog2(NB + 1);

    div_state_t    state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [NB-1:0] p_q, p_d;
    logic [NB-1:0] q_q, q_d;
    logic [NB-1:0] div_q, div_d;
    logic [NB-1:0] quot_q, quot_d;
    logic [NB-1:0] rem_q, rem_d;
    logic          dbz_q, dbz_d;
    logic          ovf_q, ovf_d;

    logic [NB-1:0] step_p;
    logic          step_q;

    imul_divider_div_step #(.NB(NB)) u_step (
        .p_in   (p_q),
        .bit_in (q_q[NB-1]),
        .divisor(div_q),
        .p_out  (step_p),
        .q_bit  (step_q)
    );

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        p_d     = p_q;
        q_d     = q_q;
        div_d   = div_q;
        quot_d  = quot_q;
        rem_d   = rem_q;
        dbz_d   = dbz_q;
        ovf_d   = ovf_q;
        case (state_q)
            ST_IDLE, ST_DONE: begin
                state_d = ST_IDLE;
                if (iStart) begin
                    if (iDivisor == '0) begin
                        state_d = ST_DONE;
                        quot_d  = '1;
                        rem_d   = '0;
                        dbz_d   = 1'b1;
                        ovf_d   = 1'b0;
                    end else if (iDividend[2*NB-1:NB] >= iDivisor) begin
                        // Quotient would need more than NB bits
                        state_d = ST_DONE;
                        quot_d  = '1;
                        rem_d   = '0;
                        dbz_d   = 1'b0;
                        ovf_d   = 1'b1;
                    end else begin
                        state_d = ST_RUN;
                        p_d     = iDividend[2*NB-1:NB];
                        q_d     = iDividend[NB-1:0];
                        div_d   = iDivisor;
                        cnt_d   = '0;
                    end
                end
            end
            ST_RUN: begin
                p_d   = step_p;
                q_d   = {q_q[NB-2:0], step_q};
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == CW'(NB - 1)) begin
                    state_d = ST_DONE;
                    quot_d  = {q_q[NB-2:0], step_q};
                    rem_d   = step_p;
                    dbz_d   = 1'b0;
                    ovf_d   = 1'b0;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge Clock or negedge Reset_n) begin
        if (!Reset_n) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            p_q     <= '0;
            q_q     <= '0;
            div_q   <= '0;
            quot_q  <= '0;
            rem_q   <= '0;
            dbz_q   <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            p_q     <= p_d;
            q_q     <= q_d;
            div_q   <= div_d;
            quot_q  <= quot_d;
            rem_q   <= rem_d;
            dbz_q   <= dbz_d;
            ovf_q   <= ovf_d;
        end
    end

    assign oBusy      = (state_q == ST_RUN);
    assign oDone      = (state_q == ST_DONE);
    assign oQuotient  = quot_q;
    assign oRemainder = rem_q;
    assign oDivByZero = dbz_q;
    assign oOverflow  = ovf_q;
endmodule

`default_nettype wire

// File: tb/tb_imul_divider.sv
// ============================================================================
//  tb_imul_divider
//  Scoreboard bench: arithmetic reference model vs. the sequential divider.
//  Revision: 1.0
// ============================================================================
`default_nettype none

module tb_imul_divider;
    localparam int NB = 16;

    logic            Clock;
    logic            Reset_n;
    logic            iStart;
    logic [2*NB-1:0] iDividend;
    logic [NB-1:0]   iDivisor;
    logic            oBusy;
    logic            oDone;
    logic [NB-1:0]   oQuotient;
    logic [NB-1:0]   oRemainder;
    logic            oDivByZero;
    logic            oOverflow;

    imul_divider #(.NB(NB)) dut (
        .Clock     (Clock),
        .Reset_n   (Reset_n),
        .iStart    (iStart),
        .iDividend (iDividend),
        .iDivisor  (iDivisor),
        .oBusy     (oBusy),
        .oDone     (oDone),
        .oQuotient (oQuotient),
        .oRemainder(oRemainder),
        .oDivByZero(oDivByZero),
        .oOverflow (oOverflow)
    );

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    typedef struct {
        logic [NB-1:0] q;
        logic [NB-1:0] r;
        logic          dbz;
        logic          ovf;
        int            lat;
        int            busy;
        int            issue;
    } exp_t;

    exp_t sb[$];
    int   checks   = 0;
    int   errors   = 0;
    int   cyc      = 0;
    int   busy_cnt = 0;

    always @(posedge Clock) cyc++;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference: plain integer division with the error cases decided first
    task automatic start_op(input logic [2*NB-1:0] dd, input logic [NB-1:0] dv);
        exp_t            e;
        longint unsigned quo;
        iDividend = dd;
        iDivisor  = dv;
        iStart    = 1'b1;
        e.dbz = 1'b0;
        e.ovf = 1'b0;
        if (dv == 0) begin
            e.dbz = 1'b1; e.q = '1; e.r = '0; e.lat = 1; e.busy = 0;
        end else begin
            quo = longint'(dd) / longint'(dv);
            if (quo >= (64'd1 << NB)) begin
                e.ovf = 1'b1; e.q = '1; e.r = '0; e.lat = 1; e.busy = 0;
            end else begin
                e.q = NB'(quo);
                e.r = NB'(longint'(dd) % longint'(dv));
                e.lat = NB + 1; e.busy = NB;
            end
        end
        e.issue = cyc;
        sb.push_back(e);
        @(posedge Clock); #1;
        iStart = 1'b0;
    endtask

    task automatic wait_done();
        bit seen = 0;
        for (int i = 0; i < 60 && !seen; i++) begin
            if (oDone) seen = 1;
            else begin
                @(posedge Clock); #1;
            end
        end
        if (!seen) begin
            checks++;
            errors++;
            $display("FAIL done_timeout: oDone not seen within 60 cycles (cycle %0d)", cyc);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge Clock); #1;
        end
    endtask

    always @(negedge Clock) begin
        if (!Reset_n) busy_cnt = 0;
        else begin
            if (oBusy) busy_cnt++;
            if (oDone) begin
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_done: oDone with empty scoreboard (cycle %0d)", cyc);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    chk("quotient",  32'(oQuotient),  32'(e.q));
                    chk("remainder", 32'(oRemainder), 32'(e.r));
                    chk("divbyzero", 32'(oDivByZero), 32'(e.dbz));
                    chk("overflow",  32'(oOverflow),  32'(e.ovf));
                    chk("latency",   32'(cyc - e.issue), 32'(e.lat));
                    chk("busy_cycles", 32'(busy_cnt), 32'(e.busy));
                end
                busy_cnt = 0;
            end
        end
    end

    initial begin
        logic [NB-1:0] a, b;
        logic [2*NB-1:0] dd;
        logic [NB-1:0]   dv;

        iStart = 1'b0; iDividend = '0; iDivisor = '0;
        Reset_n = 1'b0;
        #12;
        chk("reset_outputs", {26'd0, oBusy, oDone, oDivByZero, oOverflow, 2'b00}, 32'd0);
        chk("reset_quot_rem", {oQuotient, oRemainder}, 32'd0);
        @(posedge Clock); #2;
        Reset_n = 1'b1;
        idle(2);

        start_op(32'd1000, 16'd7);          wait_done(); idle(1);
        start_op(32'hFFFE0001, 16'hFFFF);   wait_done(); idle(1);
        start_op(32'd5, 16'd0);             wait_done(); idle(1);
        start_op(32'h00010000, 16'h0001);   wait_done(); idle(1);
        start_op(32'h0000FFFF, 16'h0001);   wait_done(); idle(1);

        // Start pulse mid-iteration must be ignored along with new operands
        start_op(32'd1000, 16'd7);
        idle(4);
        iStart = 1'b1; iDividend = 32'd12345; iDivisor = 16'd3;
        idle(1);
        iStart = 1'b0;
        wait_done(); idle(1);

        // Back-to-back: next start issued in the DONE cycle
        start_op(32'd1000, 16'd7);          wait_done();
        start_op(32'd77777, 16'd123);       wait_done();
        start_op(32'd9, 16'd0);             wait_done();
        start_op(32'd500, 16'd9);           wait_done(); idle(1);

        // Asynchronous abort part way through an operation
        start_op(32'd1000, 16'd7);
        idle(7);
        #2 Reset_n = 1'b0;
        #1;
        chk("abort_flags", {28'd0, oBusy, oDone, oDivByZero, oOverflow}, 32'd0);
        chk("abort_quot_rem", {oQuotient, oRemainder}, 32'd0);
        sb.delete();
        idle(2);
        #1 Reset_n = 1'b1;
        idle(1);
        start_op(32'd99, 16'd10);           wait_done(); idle(1);

        // Multiplier round trip: (A*B)/B == A remainder 0
        for (int i = 0; i < 100; i++) begin
            a = NB'($urandom);
            b = NB'($urandom_range(1, 65535));
            start_op(32'(a) * 32'(b), b);
            wait_done();
            if (i % 2 == 0) idle(1);
        end

        // General random operands, including small divisors and zero
        for (int i = 0; i < 60; i++) begin
            dd = $urandom;
            if (i % 3 == 0) dd = dd >> $urandom_range(8, 31);
            dv = ($urandom_range(0, 3) == 0) ? NB'($urandom_range(0, 20)) : NB'($urandom);
            start_op(dd, dv);
            wait_done();
            if (i % 2 == 1) idle(1);
        end

        idle(3);
        chk("scoreboard_empty", 32'(sb.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

`default_nettype wire
